// File: rtl/ncl_add_sequencer.sv
// Clocked sequencer driving DATA/NULL wavefronts into a dual-rail NCL adder.
// Operands are encoded to dual-rail, completion is observed through
// synchronizers, and the decoded sum is returned over a valid/ready response.
module ncl_add_sequencer #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [WIDTH-1:0]   req_a,
   input  logic [WIDTH-1:0]   req_b,
   input  logic               req_cin,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WIDTH-1:0]   rsp_sum,
   output logic               rsp_cout,
   output logic               rsp_err,
   output logic               stuck,
   output logic [2*WIDTH-1:0] a_dr,
   output logic [2*WIDTH-1:0] b_dr,
   output logic [1:0]         cin_dr,
   input  logic               adder_ko,
   input  logic [2*WIDTH-1:0] sum_dr,
   input  logic [1:0]         cout_dr
);

   localparam int unsigned DRW  = 2 * WIDTH;
   localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_DRAIN,
      S_IDLE,
      S_DATA,
      S_NULLW,
      S_RESP
   } state_t;

   state_t state, state_nx;

   logic [SYNC_STAGES-1:0]          ko_sync;
   logic [SYNC_STAGES-1:0][DRW-1:0] sum_sync;
   logic [SYNC_STAGES-1:0][1:0]     cout_sync;

   logic            ko_s;
   logic [DRW-1:0]  sum_s;
   logic [1:0]      cout_s;
   logic [CNTW-1:0] cnt;
   logic            cnt_max;

   logic             all_valid, all_null, illegal;
   logic             data_done, null_done;
   logic [WIDTH-1:0] sum_dec;

   logic accept, capture, err_set, ok_resp, stuck_set;

   // Single-rail to dual-rail: 1 -> 10, 0 -> 01
   function automatic logic [DRW-1:0] encode(input logic [WIDTH-1:0] x);
      logic [DRW-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         r[2*i +: 2] = x[i] ? 2'b10 : 2'b01;
      end
      return r;
   endfunction

   // Synchronizer chains for the asynchronous adder outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         ko_sync   <= '0;
         sum_sync  <= '0;
         cout_sync <= '0;
      end else begin
         ko_sync   <= {ko_sync[SYNC_STAGES-2:0], adder_ko};
         sum_sync  <= {sum_sync[SYNC_STAGES-2:0], sum_dr};
         cout_sync <= {cout_sync[SYNC_STAGES-2:0], cout_dr};
      end
   end

   assign ko_s    = ko_sync[SYNC_STAGES-1];
   assign sum_s   = sum_sync[SYNC_STAGES-1];
   assign cout_s  = cout_sync[SYNC_STAGES-1];
   assign cnt_max = (cnt == CNTW'(TIMEOUT));

   // Rail-pair classification of the synchronized sum and carry
   always_comb begin
      all_valid = ^cout_s;
      all_null  = ~|cout_s;
      illegal   = &cout_s;
      sum_dec   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         all_valid  = all_valid & (^sum_s[2*i +: 2]);
         all_null   = all_null & ~(|sum_s[2*i +: 2]);
         illegal    = illegal | (&sum_s[2*i +: 2]);
         sum_dec[i] = sum_s[2*i+1];
      end
      data_done = all_valid & ~ko_s;
      null_done = all_null & ko_s;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_DRAIN;
      else       state <= state_nx;
   end

   // Next-state and event decode; illegal beats done beats timeout
   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      capture   = 1'b0;
      err_set   = 1'b0;
      ok_resp   = 1'b0;
      stuck_set = 1'b0;
      unique case (state)
         S_DRAIN: begin
            if (null_done)    state_nx = S_IDLE;
            else if (cnt_max) stuck_set = 1'b1;
         end
         S_IDLE: begin
            if (req_valid && req_ready) begin
               accept   = 1'b1;
               state_nx = S_DATA;
            end
         end
         S_DATA: begin
            if (illegal) begin
               err_set  = 1'b1;
               state_nx = S_RESP;
            end else if (data_done) begin
               capture  = 1'b1;
               state_nx = S_NULLW;
            end else if (cnt_max) begin
               err_set  = 1'b1;
               state_nx = S_RESP;
            end
         end
         S_NULLW: begin
            if (illegal) begin
               err_set  = 1'b1;
               state_nx = S_RESP;
            end else if (null_done) begin
               ok_resp  = 1'b1;
               state_nx = S_RESP;
            end else if (cnt_max) begin
               err_set  = 1'b1;
               state_nx = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_nx = rsp_err ? S_DRAIN : S_IDLE;
         end
         default: state_nx = S_DRAIN;
      endcase
   end

   // Wait counter: clears on any state change, saturates at TIMEOUT
   always_ff @(posedge clk) begin
      if (reset)                 cnt <= '0;
      else if (state_nx != state) cnt <= '0;
      else if (!cnt_max)          cnt <= cnt + CNTW'(1);
   end

   // Dual-rail operand drive: DATA only while in DATA, NULL otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         a_dr   <= '0;
         b_dr   <= '0;
         cin_dr <= '0;
      end else if (accept) begin
         a_dr   <= encode(req_a);
         b_dr   <= encode(req_b);
         cin_dr <= req_cin ? 2'b10 : 2'b01;
      end else if (state_nx != S_DATA) begin
         a_dr   <= '0;
         b_dr   <= '0;
         cin_dr <= '0;
      end
   end

   // Handshake, response and sticky status registers
   always_ff @(posedge clk) begin
      if (reset) begin
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         stuck     <= 1'b0;
      end else begin
         req_ready <= (state_nx == S_IDLE);
         rsp_valid <= (state_nx == S_RESP);
         if (capture) begin
            rsp_sum  <= sum_dec;
            rsp_cout <= cout_s[1];
         end
         if (err_set)      rsp_err <= 1'b1;
         else if (ok_resp) rsp_err <= 1'b0;
         if (stuck_set) stuck <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ncl_add_sequencer.sv
// Bench for ncl_add_sequencer with a behavioural dual-rail adder model.
module tb_ncl_add_sequencer;

   localparam int unsigned W     = 8;
   localparam int unsigned TO    = 40;
   localparam int          BOUND = 2 * TO + 50;

   localparam int M_IDEAL   = 0;
   localparam int M_HANG    = 1;
   localparam int M_ILLEGAL = 2;
   localparam int M_HOLD    = 3;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         err;
   } rsp_t;

   logic           clk;
   logic           reset;
   logic           req_valid;
   logic           req_ready;
   logic [W-1:0]   req_a;
   logic [W-1:0]   req_b;
   logic           req_cin;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [W-1:0]   rsp_sum;
   logic           rsp_cout;
   logic           rsp_err;
   logic           stuck;
   logic [2*W-1:0] a_dr;
   logic [2*W-1:0] b_dr;
   logic [1:0]     cin_dr;
   logic           adder_ko;
   logic [2*W-1:0] sum_dr;
   logic [1:0]     cout_dr;

   int   total = 0;
   int   bad   = 0;
   int   mode  = M_IDEAL;
   rsp_t exp_q[$];
   logic [W-1:0] last_sum  = '0;
   logic         last_cout = 1'b0;
   logic [W:0]   model_s;

   ncl_add_sequencer #(
      .WIDTH       (W),
      .TIMEOUT     (TO),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_err   (rsp_err),
      .stuck     (stuck),
      .a_dr      (a_dr),
      .b_dr      (b_dr),
      .cin_dr    (cin_dr),
      .adder_ko  (adder_ko),
      .sum_dr    (sum_dr),
      .cout_dr   (cout_dr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] tb_enc(input logic [W-1:0] x);
      logic [2*W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) r[2*i +: 2] = x[i] ? 2'b10 : 2'b01;
      return r;
   endfunction

   function automatic logic [W-1:0] tb_dec(input logic [2*W-1:0] x);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = x[2*i+1];
      return r;
   endfunction

   function automatic logic tb_complete(input logic [2*W-1:0] x);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < W; i++)
         if (x[2*i +: 2] != 2'b01 && x[2*i +: 2] != 2'b10) ok = 1'b0;
      return ok;
   endfunction

   // Zero-delay adder model with fault modes
   always_comb begin
      model_s  = (W+1)'(tb_dec(a_dr)) + (W+1)'(tb_dec(b_dr)) + (W+1)'(cin_dr[1]);
      adder_ko = 1'b1;
      sum_dr   = '0;
      cout_dr  = '0;
      if (mode == M_HOLD) begin
         sum_dr   = tb_enc(8'h3C);
         cout_dr  = 2'b01;
         adder_ko = 1'b0;
      end else if (mode != M_HANG && tb_complete(a_dr) && tb_complete(b_dr) &&
                   (cin_dr == 2'b01 || cin_dr == 2'b10)) begin
         sum_dr   = tb_enc(model_s[W-1:0]);
         cout_dr  = model_s[W] ? 2'b10 : 2'b01;
         adder_ko = 1'b0;
         if (mode == M_ILLEGAL) sum_dr[7:6] = 2'b11;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction: push expectation, drive, await response, compare, release
   task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic exp_err, input int exp_lat, input int stall);
      rsp_t       e;
      rsp_t       got;
      logic [W:0] s;
      int         k;
      k = 0;
      while (!req_ready && k < BOUND) begin tick(); k++; end
      check("req_ready_wait", req_ready, 1);
      if (exp_err) begin
         e = '{sum: last_sum, cout: last_cout, err: 1'b1};
      end else begin
         s = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
         e = '{sum: s[W-1:0], cout: s[W], err: 1'b0};
         last_sum  = s[W-1:0];
         last_cout = s[W];
      end
      exp_q.push_back(e);
      req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("a_dr_encoded", a_dr, tb_enc(a));
      check("cin_dr_encoded", cin_dr, cin ? 2'b10 : 2'b01);
      k = 0;
      while (!rsp_valid && k < BOUND) begin tick(); k++; end
      check("rsp_valid_seen", rsp_valid, 1);
      if (exp_lat >= 0) check("rsp_latency", k, exp_lat);
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         got = '{sum: rsp_sum, cout: rsp_cout, err: rsp_err};
         check("rsp_payload", got, e);
      end
      for (int i = 0; i < stall; i++) begin
         tick();
         check("stall_valid", rsp_valid, 1);
         check("stall_payload", {rsp_sum, rsp_cout, rsp_err}, {e.sum, e.cout, e.err});
         check("stall_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_valid_drop", rsp_valid, 0);
      check("post_rsp_ready", req_ready, exp_err ? 0 : 1);
   endtask

   initial begin
      int  k;
      logic seen_valid;
      reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0;
      rsp_ready = 1'b0; mode = M_IDEAL;

      // 1: reset with idle adder
      tick(); tick(); tick();
      check("rst_req_ready", req_ready, 0);
      check("rst_stuck", stuck, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_a_dr", a_dr, 0);
      check("rst_rsp_sum", {rsp_sum, rsp_cout, rsp_err}, 0);
      reset = 1'b0;
      tick(); check("ready_c1", req_ready, 0);
      tick(); check("ready_c2", req_ready, 0);
      tick(); check("ready_c3", req_ready, 1);
      check("stuck_after_rst", stuck, 0);

      // 2: carry ripple across all bits
      run_txn(8'hFF, 8'h01, 1'b0, 1'b0, 6, 0);

      // 3: held response
      run_txn(8'hA5, 8'h5A, 1'b1, 1'b0, 6, 10);

      // a few extra patterns
      for (int i = 0; i < 4; i++)
         run_txn(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 6, i);

      // 4: adder never completes DATA
      mode = M_HANG;
      run_txn(8'h11, 8'h22, 1'b0, 1'b1, -1, 0);
      mode = M_IDEAL;
      tick();
      check("hang_recover_ready", req_ready, 1);

      // 5: illegal rail code on pair 3, then a clean transaction
      mode = M_ILLEGAL;
      run_txn(8'h0F, 8'h10, 1'b0, 1'b1, -1, 0);
      mode = M_IDEAL;
      run_txn(8'h03, 8'h04, 1'b0, 1'b0, 6, 0);
      check("three_plus_four", rsp_sum, 8'h07);

      // 6: reset mid-transaction, then adder stuck non-NULL
      k = 0;
      while (!req_ready && k < BOUND) begin tick(); k++; end
      req_a = 8'h12; req_b = 8'h34; req_cin = 1'b0; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      check("pre_abort_a_dr", a_dr, tb_enc(8'h12));
      mode  = M_HOLD;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_a_dr", a_dr, 0);
      check("abort_b_dr", b_dr, 0);
      check("abort_cin_dr", cin_dr, 0);
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_req_ready", req_ready, 0);
      seen_valid = 1'b0;
      for (int i = 0; i < int'(TO) - 3; i++) begin
         tick();
         seen_valid = seen_valid | rsp_valid;
      end
      check("stuck_early", stuck, 0);
      k = 0;
      while (!stuck && k < 10) begin
         tick(); k++;
         seen_valid = seen_valid | rsp_valid;
      end
      check("stuck_set", stuck, 1);
      check("abort_no_rsp", seen_valid, 0);
      check("drain_not_ready", req_ready, 0);
      mode = M_IDEAL;
      k = 0;
      while (!req_ready && k < BOUND) begin tick(); k++; end
      check("drain_exit_ready", req_ready, 1);
      check("stuck_sticky", stuck, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
